// File: rtl/uart_regfile_pkg.sv
// Shared definitions for the UART register-file link: frame marker,
// response status codes, serializer state encoding and checksum helper.
package uart_regfile_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BADCMD  = 8'h01;
  localparam logic [7:0] STAT_BADADDR = 8'h02;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_STATUS = 3'd2;
  localparam logic [2:0] ST_ADDR   = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_CSUM   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SYNC   = ST_SYNC,
    S_STATUS = ST_STATUS,
    S_ADDR   = ST_ADDR,
    S_DATA   = ST_DATA,
    S_CSUM   = ST_CSUM
  } ser_state_t;

  // Frame checksum: plain byte-wise XOR, no carry.
  function automatic logic [7:0] csum8(input logic [7:0] s, input logic [7:0] a,
                                       input logic [7:0] d);
    return s ^ a ^ d;
  endfunction

endpackage

// File: rtl/rsp_serializer.sv
// Response serializer: takes one (status, addr, data) response from the
// register-file controller and streams [SYNC] STATUS ADDR DATA [CSUM] to uart_tx.
module rsp_serializer
  import uart_regfile_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter bit         SEND_SYNC = 1'b1,
  parameter bit         SEND_CSUM = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_status,
  input  logic [7:0] rsp_addr,
  input  logic [7:0] rsp_data,
  output logic       rsp_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       frame_done,
  output logic       busy
);

  ser_state_t r_state;
  logic [7:0] r_status;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_csum;
  logic       r_tx_valid;
  logic [7:0] r_tx_data;
  logic       r_frame_done;
  logic       r_busy;

  // Ready is decoded from state, held low while reset is asserted.
  assign rsp_ready  = rst_n & (r_state == S_IDLE);
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

  // Frame FSM: latch response, then present one byte per accepted handshake.
  // tx_data is loaded with the next byte on each transition so it is stable
  // while uart_tx stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_status     <= 8'h00;
      r_addr       <= 8'h00;
      r_data       <= 8'h00;
      r_csum       <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (rsp_valid) begin
          r_status   <= rsp_status;
          r_addr     <= rsp_addr;
          r_data     <= rsp_data;
          r_csum     <= csum8(rsp_status, rsp_addr, rsp_data);
          r_busy     <= 1'b1;
          r_tx_valid <= 1'b1;
          if (SEND_SYNC) begin
            r_state   <= S_SYNC;
            r_tx_data <= SYNC_BYTE;
          end else begin
            r_state   <= S_STATUS;
            r_tx_data <= rsp_status;
          end
        end
      end else if (tx_ready) begin
        // Byte states always have tx_valid high, so tx_ready alone is the accept.
        case (r_state)
          S_SYNC: begin
            r_state   <= S_STATUS;
            r_tx_data <= r_status;
          end
          S_STATUS: begin
            r_state   <= S_ADDR;
            r_tx_data <= r_addr;
          end
          S_ADDR: begin
            r_state   <= S_DATA;
            r_tx_data <= r_data;
          end
          S_DATA: begin
            if (SEND_CSUM) begin
              r_state   <= S_CSUM;
              r_tx_data <= r_csum;
            end else begin
              r_state      <= S_IDLE;
              r_tx_valid   <= 1'b0;
              r_tx_data    <= 8'h00;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end
          end
          default: begin
            // S_CSUM: last byte of a full frame.
            r_state      <= S_IDLE;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsp_serializer.sv
// Directed bench for rsp_serializer: full frame, stalls, reduced frame,
// back-to-back responses, mid-frame reset and input isolation.
module tb_rsp_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_rsp_valid = 1'b0;
  logic       b_rsp_valid = 1'b0;
  logic [7:0] rsp_status = 8'h00;
  logic [7:0] rsp_addr = 8'h00;
  logic [7:0] rsp_data = 8'h00;
  logic       tx_ready = 1'b0;

  logic       a_rsp_ready, a_tx_valid, a_frame_done, a_busy;
  logic [7:0] a_tx_data;
  logic       b_rsp_ready, b_tx_valid, b_frame_done, b_busy;
  logic [7:0] b_tx_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] got [0:7];
  int         got_n;
  int         cycles;

  always #5 clk = ~clk;

  rsp_serializer u_full (
    .clk(clk), .rst_n(rst_n),
    .rsp_valid(a_rsp_valid), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_ready(a_rsp_ready),
    .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(tx_ready),
    .frame_done(a_frame_done), .busy(a_busy)
  );

  rsp_serializer #(.SEND_SYNC(1'b0), .SEND_CSUM(1'b0)) u_bare (
    .clk(clk), .rst_n(rst_n),
    .rsp_valid(b_rsp_valid), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_ready(b_rsp_ready),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(tx_ready),
    .frame_done(b_frame_done), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Run a frame out of the selected DUT with tx_ready driven from pat (bit per
  // cycle), recording accepted bytes and checking data holds while stalled.
  task automatic drain(input bit sel, input logic [31:0] pat, input string tag);
    logic       vld, fd, hold_pend;
    logic [7:0] dat, hold_val;
    bit         done;
    got_n     = 0;
    cycles    = 0;
    hold_pend = 1'b0;
    hold_val  = 8'h00;
    done      = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tx_ready = (c < 32) ? pat[c] : 1'b1;
      vld = sel ? b_tx_valid : a_tx_valid;
      dat = sel ? b_tx_data : a_tx_data;
      if (hold_pend) begin
        chk({tag, "_hold"}, {24'h0, dat}, {24'h0, hold_val});
        hold_pend = 1'b0;
      end
      if (vld) begin
        if (tx_ready) begin
          if (got_n < 8) got[got_n] = dat;
          got_n++;
        end else begin
          hold_pend = 1'b1;
          hold_val  = dat;
        end
      end
      tick();
      cycles = c + 1;
      fd = sel ? b_frame_done : a_frame_done;
      if (fd) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_frame_done_seen"}, {31'h0, done}, 32'h1);
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [39:0] exp);
    logic [39:0] e;
    e = exp;
    chk({tag, "_count"}, got_n, n);
    for (int i = 0; i < n && i < got_n; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, got[i]},
          {24'h0, e[8*(n-1-i) +: 8]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state
    tick();
    chk("rst_tx_valid", {31'h0, a_tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, a_tx_data}, 32'h0);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_frame_done", {31'h0, a_frame_done}, 32'h0);
    chk("rst_rsp_ready_low", {31'h0, a_rsp_ready}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_rsp_ready_high", {31'h0, a_rsp_ready}, 32'h1);

    // ---- 1: full frame, tx_ready held high
    rsp_status = 8'h00; rsp_addr = 8'h12; rsp_data = 8'h34;
    a_rsp_valid = 1'b1; tx_ready = 1'b1;
    tick();
    a_rsp_valid = 1'b0;
    chk("t1_first_valid", {31'h0, a_tx_valid}, 32'h1);
    chk("t1_first_byte", {24'h0, a_tx_data}, 32'hA5);
    chk("t1_busy", {31'h0, a_busy}, 32'h1);
    chk("t1_rsp_ready_low", {31'h0, a_rsp_ready}, 32'h0);
    drain(1'b0, 32'hFFFF_FFFF, "t1");
    chk_bytes("t1", 5, 40'hA5_00_12_34_26);
    chk("t1_cycles", cycles, 5);
    chk("t1_busy_drop", {31'h0, a_busy}, 32'h0);
    chk("t1_tx_valid_drop", {31'h0, a_tx_valid}, 32'h0);
    chk("t1_rsp_ready_back", {31'h0, a_rsp_ready}, 32'h1);
    tick();
    chk("t1_frame_done_pulse", {31'h0, a_frame_done}, 32'h0);

    // ---- 2: stalls with tx_ready 1-0-0-1
    a_rsp_valid = 1'b1;
    tick();
    a_rsp_valid = 1'b0;
    drain(1'b0, 32'hFFFF_FFF9, "t2");
    chk_bytes("t2", 5, 40'hA5_00_12_34_26);
    chk("t2_cycles", cycles, 7);

    // ---- 3: no SYNC, no CSUM
    rsp_status = 8'h02; rsp_addr = 8'hFF; rsp_data = 8'h00;
    b_rsp_valid = 1'b1;
    tick();
    b_rsp_valid = 1'b0;
    chk("t3_first_byte", {24'h0, b_tx_data}, 32'h02);
    drain(1'b1, 32'hFFFF_FFFF, "t3");
    chk_bytes("t3", 3, {16'h0, 24'h02_FF_00});
    chk("t3_cycles", cycles, 3);

    // ---- 4: back-to-back with rsp_valid held high
    rsp_status = 8'h00; rsp_addr = 8'h01; rsp_data = 8'hAA;
    a_rsp_valid = 1'b1;
    tick();
    drain(1'b0, 32'hFFFF_FFFF, "t4a");
    chk_bytes("t4a", 5, 40'hA5_00_01_AA_AB);
    chk("t4_gap_tx_valid", {31'h0, a_tx_valid}, 32'h0);
    chk("t4_gap_rsp_ready", {31'h0, a_rsp_ready}, 32'h1);
    rsp_status = 8'h01; rsp_addr = 8'h02; rsp_data = 8'hBB;
    tick();
    a_rsp_valid = 1'b0;
    chk("t4b_first_byte", {24'h0, a_tx_data}, 32'hA5);
    drain(1'b0, 32'hFFFF_FFFF, "t4b");
    chk_bytes("t4b", 5, 40'hA5_01_02_BB_B8);

    // ---- 5: reset after ADDR accepted
    rsp_status = 8'h00; rsp_addr = 8'h12; rsp_data = 8'h34;
    a_rsp_valid = 1'b1; tx_ready = 1'b1;
    tick();
    a_rsp_valid = 1'b0;
    tick(); tick(); tick();
    tx_ready = 1'b0;
    chk("t5_at_data", {24'h0, a_tx_data}, 32'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tx_valid", {31'h0, a_tx_valid}, 32'h0);
    chk("t5_async_tx_data", {24'h0, a_tx_data}, 32'h0);
    chk("t5_async_busy", {31'h0, a_busy}, 32'h0);
    tick();
    chk("t5_no_done_in_rst", {31'h0, a_frame_done}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t5_no_done_after", {31'h0, a_frame_done}, 32'h0);
    chk("t5_idle_tx_valid", {31'h0, a_tx_valid}, 32'h0);
    rsp_status = 8'h02; rsp_addr = 8'h56; rsp_data = 8'h78;
    a_rsp_valid = 1'b1;
    tick();
    a_rsp_valid = 1'b0;
    drain(1'b0, 32'hFFFF_FFFF, "t5");
    chk_bytes("t5", 5, 40'hA5_02_56_78_2C);

    // ---- 6: inputs change after acceptance
    rsp_status = 8'h01; rsp_addr = 8'h9A; rsp_data = 8'hBC;
    a_rsp_valid = 1'b1;
    tick();
    a_rsp_valid = 1'b0;
    rsp_status = 8'hFF; rsp_addr = 8'hFF; rsp_data = 8'hFF;
    drain(1'b0, 32'hFFFF_FFFF, "t6");
    chk_bytes("t6", 5, 40'hA5_01_9A_BC_27);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
